temp_reverse_converter: RTL and testbench

//  Inverse of the C->C/F/K temperature converter: takes a reading in a selected scale (C, F or K)
//  and converts it back to Celsius. A multi-cycle FSM with a load/start interface is used.
//  F->C division by 5 is done by sequential repeated subtraction.

---
 rtl/temp_conv_pkg.sv | 25 ++
 rtl/seq_div5.sv | 70 +++++++
 rtl/temp_reverse_converter.sv | 164 ++++++++++++++++
 tb/tb_temp_reverse_converter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/temp_conv_pkg.sv
// Shared definitions for the temperature converter blocks.
//   scale_e         : source/target scale encoding (C, F, K, invalid)
//   revconv_state_e : reverse-converter FSM states
//   K_OFF_DEF/F_OFF_DEF : default scale offsets; DIV5 : divisor for the F path
package temp_conv_pkg;

  typedef enum logic [1:0] {
    SCALE_C   = 2'b00,
    SCALE_F   = 2'b01,
    SCALE_K   = 2'b10,
    SCALE_INV = 2'b11
  } scale_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } revconv_state_e;

  localparam int unsigned K_OFF_DEF = 3;
  localparam int unsigned F_OFF_DEF = 2;
  localparam int unsigned DIV5      = 5;

endpackage

// File: rtl/seq_div5.sv
// Sequential divide-by-5 by repeated subtraction, one subtraction per clock.
// Ports:
//   clk      in  : clock, rising edge
//   clr      in  : synchronous active-high reset
//   start    in  : load dividend, clear quotient, begin dividing
//   dividend in  : QW+3-bit unsigned dividend
//   busy     out : another subtraction is still pending; low in the final division cycle
//   q        out : quotient so far (final once busy is low)
//   ovf      out : quotient would exceed QW bits; valid in the final division cycle
// busy/ovf are combinational on the current remainder so the owner can leave its wait state
// on the very edge that ends the division, without a trailing idle cycle.
module seq_div5
  import temp_conv_pkg::*;
#(
  parameter int unsigned QW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [QW+2:0] dividend,
  output logic          busy,
  output logic [QW-1:0] q,
  output logic          ovf
);

  localparam int unsigned RW = QW + 3;
  localparam logic [RW-1:0] Divisor = RW'(DIV5);

  logic [RW-1:0] rem_q, rem_d;
  logic [QW-1:0] q_q, q_d;
  logic          run_q, run_d;
  logic          can_sub;
  logic          q_max;

  always_comb begin
    can_sub = (rem_q >= Divisor);
    q_max   = &q_q;
    busy    = run_q && can_sub && !q_max;
    // A further subtraction with the quotient already all-ones would wrap it.
    ovf     = run_q && can_sub && q_max;
    q       = q_q;

    rem_d = rem_q;
    q_d   = q_q;
    run_d = run_q;
    if (start) begin
      rem_d = dividend;
      q_d   = '0;
      run_d = 1'b1;
    end else if (busy) begin
      rem_d = rem_q - Divisor;
      q_d   = q_q + 1'b1;
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rem_q <= '0;
      q_q   <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      q_q   <= q_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/temp_reverse_converter.sv
// Reverse temperature converter: reading in C, F or K back to Celsius.
//   C -> C : X
//   K -> C : X - K_OFFSET
//   F -> C : floor((X - F_OFFSET) * 8 / 5), division done sequentially by seq_div5
// Load/start handshake; a multi-cycle FSM (IDLE -> SUB -> [DIV...] -> DONE -> IDLE).
// Ports:
//   clk   in  : clock, rising edge
//   clr   in  : synchronous active-high reset; aborts any conversion in flight
//   X     in  : input temperature (WIDTH bits)
//   sel   in  : source scale 00=C 01=F 10=K 11=invalid
//   ld    in  : capture X/sel into operand registers (IDLE only)
//   st    in  : start a conversion of the captured operands (IDLE only)
//   c_out out : Celsius result, held until the next conversion completes or clr
//   busy  out : high in every state except IDLE
//   done  out : one-cycle pulse when c_out/err become valid
//   err   out : underflow, overflow or invalid scale on the last conversion
// Configuration macro: REVCONV_ROUND_EN -- F path rounds to nearest instead of flooring.
module temp_reverse_converter
  import temp_conv_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned K_OFFSET = K_OFF_DEF,
  parameter int unsigned F_OFFSET = F_OFF_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] X,
  input  logic [1:0]       sel,
  input  logic             ld,
  input  logic             st,
  output logic [WIDTH-1:0] c_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = WIDTH + 3;
  localparam logic [WIDTH-1:0] KOff = WIDTH'(K_OFFSET);
  localparam logic [WIDTH-1:0] FOff = WIDTH'(F_OFFSET);

  revconv_state_e   state_q, state_d;
  logic [WIDTH-1:0] op_x_q, op_x_d;
  scale_e           op_sel_q, op_sel_d;
  logic [WIDTH-1:0] c_out_q, c_out_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] diff;
  logic             underflow;

  logic             div_start;
  logic [RW-1:0]    div_dividend;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic             div_ovf;

  // Offset stage, evaluated on the captured operands.
  always_comb begin
    unique case (op_sel_q)
      SCALE_C:   offset = '0;
      SCALE_F:   offset = FOff;
      SCALE_K:   offset = KOff;
      SCALE_INV: offset = '0;
      default:   offset = '0;
    endcase
    underflow = (op_x_q < offset);
    diff      = op_x_q - offset;
`ifdef REVCONV_ROUND_EN
    // +2 before dividing by 5 turns floor(diff*8/5) into a round-to-nearest of diff*1.6.
    div_dividend = {diff, 3'b000} + RW'(2);
`else
    div_dividend = {diff, 3'b000};
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_x_d    = op_x_q;
    op_sel_d  = op_sel_q;
    c_out_d   = c_out_q;
    err_d     = err_q;
    div_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld) begin
          op_x_d   = X;
          op_sel_d = scale_e'(sel);
        end
        // With ld and st together, SUB sees the operands loaded on this same edge.
        if (st) begin
          state_d = SUB;
        end
      end

      SUB: begin
        if (op_sel_q == SCALE_INV || underflow) begin
          c_out_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (op_sel_q == SCALE_F) begin
          div_start = 1'b1;
          state_d   = DIV;
        end else begin
          c_out_d = diff;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DIV: begin
        if (!div_busy) begin
          c_out_d = div_ovf ? '1 : div_q;
          err_d   = div_ovf;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      op_x_q   <= '0;
      op_sel_q <= SCALE_C;
      c_out_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_x_q   <= op_x_d;
      op_sel_q <= op_sel_d;
      c_out_q  <= c_out_d;
      err_q    <= err_d;
    end
  end

  seq_div5 #(
    .QW (WIDTH)
  ) u_div (
    .clk      (clk),
    .clr      (clr),
    .start    (div_start),
    .dividend (div_dividend),
    .busy     (div_busy),
    .q        (div_q),
    .ovf      (div_ovf)
  );

  always_comb begin
    c_out = c_out_q;
    err   = err_q;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
  end

endmodule

// File: tb/tb_temp_reverse_converter.sv
// Self-checking bench for temp_reverse_converter (WIDTH=4, default offsets).
module tb_temp_reverse_converter;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] X;
  logic [1:0] sel;
  logic       ld;
  logic       st;
  logic [3:0] c_out;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Result the DUT is expected to be holding right now.
  int exp_c   = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  temp_reverse_converter #(
    .WIDTH    (4),
    .K_OFFSET (3),
    .F_OFFSET (2)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .X     (X),
    .sel   (sel),
    .ld    (ld),
    .st    (st),
    .c_out (c_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: Celsius value, error flag and done latency straight from the scale rules.
  function automatic void model(input int x, input int s, output int c, output int e,
                                output int lat);
    int off;
    int d;
    int n;
    int q;
    if (s == 3) begin
      c = 0; e = 1; lat = 2;
      return;
    end
    off = (s == 1) ? 2 : (s == 2) ? 3 : 0;
    if (x < off) begin
      c = 0; e = 1; lat = 2;
      return;
    end
    d = x - off;
    if (s != 1) begin
      c = d; e = 0; lat = 2;
      return;
    end
    n = d * 8;
`ifdef REVCONV_ROUND_EN
    n = n + 2;
`endif
    q = n / 5;
    if (q > 15) begin
      // Division gives up after 16 steps when the quotient would pass 15.
      c = 15; e = 1; lat = 3 + 15;
    end else begin
      c = q; e = 0; lat = 3 + q;
    end
  endfunction

  // same: ld and st together; inj_at: cycle to pulse ld+st with bogus X; clr_at: abort cycle.
  task automatic convert(input string tag, input int x, input int s, input bit same,
                         input int inj_at, input int clr_at);
    int c, e, lat, k;
    int hold_c, hold_e;
    bit stable, busy_ok, seen, spurious;
    model(x, s, c, e, lat);
    hold_c = exp_c;
    hold_e = exp_err;

    @(negedge clk);
    X = 4'(x); sel = 2'(s); ld = 1'b1; st = same;
    if (!same) begin
      @(negedge clk);
      // Scramble inputs on the start cycle: only the loaded operands may be used.
      ld = 1'b0; st = 1'b1; X = ~4'(x); sel = 2'(s + 1);
    end
    @(negedge clk);
    ld = 1'b0; st = 1'b0; X = 4'($urandom); sel = 2'($urandom);

    k = 1; stable = 1'b1; busy_ok = 1'b1; seen = 1'b0;
    while (k <= 40) begin
      if (clr_at == k) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check($sformatf("%s_abort_busy", tag), 32'(busy), 32'(0));
        check($sformatf("%s_abort_c", tag), 32'(c_out), 32'(0));
        check($sformatf("%s_abort_err", tag), 32'(err), 32'(0));
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
          if (done || busy) spurious = 1'b1;
          @(negedge clk);
        end
        check($sformatf("%s_abort_quiet", tag), 32'(spurious), 32'(0));
        exp_c = 0;
        exp_err = 0;
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (32'(c_out) != hold_c || 32'(err) != hold_e) stable = 1'b0;
      if (!busy) busy_ok = 1'b0;
      ld = (inj_at == k);
      st = (inj_at == k);
      if (inj_at == k) begin
        X = ~4'(x);
        sel = 2'b00;
      end
      @(negedge clk);
      ld = 1'b0;
      st = 1'b0;
      k++;
    end

    check($sformatf("%s_seen", tag), 32'(seen), 32'(1));
    check($sformatf("%s_lat", tag), 32'(k), 32'(lat));
    check($sformatf("%s_c", tag), 32'(c_out), 32'(c));
    check($sformatf("%s_err", tag), 32'(err), 32'(e));
    check($sformatf("%s_held", tag), 32'(stable), 32'(1));
    check($sformatf("%s_busy", tag), 32'(busy_ok), 32'(1));
    @(negedge clk);
    check($sformatf("%s_pulse", tag), 32'(done), 32'(0));
    check($sformatf("%s_idle", tag), 32'(busy), 32'(0));
    check($sformatf("%s_keep", tag), 32'(c_out), 32'(c));
    exp_c = c;
    exp_err = e;
  endtask

  initial begin
    clr = 1'b1; X = '0; sel = '0; ld = 1'b0; st = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_c", 32'(c_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    clr = 1'b0;

    convert("t1_c5", 5, 0, 1'b1, 0, 0);
    convert("t2_k10", 10, 2, 1'b0, 0, 0);
    convert("t2_k2", 2, 2, 1'b0, 0, 0);
    convert("t3_f11", 11, 1, 1'b1, 0, 0);
    convert("t3_f6", 6, 1, 1'b0, 0, 0);
    convert("t3_f7", 7, 1, 1'b1, 0, 0);
    convert("t3_f1", 1, 1, 1'b1, 0, 0);
    convert("t4_f15", 15, 1, 1'b1, 0, 0);
    convert("t5_inj", 11, 1, 1'b1, 3, 0);
    convert("t6_clr", 15, 1, 1'b1, 0, 5);
    convert("t6_fresh", 11, 1, 1'b0, 0, 0);
    convert("inv", 9, 3, 1'b1, 0, 0);
    convert("k_min", 3, 2, 1'b1, 0, 0);
    convert("c_max", 15, 0, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      convert($sformatf("rnd%0d", i), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
